memoria_64: RTL and testbench
=============================

MEMORIA_64 -- requirements
Module: memoria_64

Interface
REQ-001 Parameter RAM_SIZE, default 4096, storage size in bytes; SHALL be a power of two, minimum 8.
REQ-002 Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 nrst  input  1  reset, asynchronous assert, active-low.
REQ-004 raddress  input  64  byte address of the doubleword read.
REQ-005 waddress  input  64  byte address of the doubleword written.
REQ-006 Datain  input  64  write data.
REQ-007 Wr  input  1  write enable, active-high, sampled at rising Clk.
REQ-008 Dataout  output  64  read data, registered.

Function
REQ-009 Storage SHALL be RAM_SIZE bytes, byte-addressed; each access covers 8 consecutive bytes starting at the given address.
REQ-010 Byte order SHALL be little-endian: byte at address A maps to bits [7:0], A+7 to bits [63:56].
REQ-011 Effective byte index SHALL be (address + k) mod RAM_SIZE for k = 0..7; upper address bits are ignored, so accesses wrap at the top of memory.
REQ-012 Unaligned addresses SHALL be legal and handled byte-exactly per REQ-011; no alignment error signal.
REQ-013 Write: at rising Clk with Wr=1 and nrst=1, all 8 bytes of Datain SHALL be stored at waddress; with Wr=0, memory is unchanged.
REQ-014 Read: at every rising Clk with nrst=1, Dataout SHALL load the 8 bytes at raddress; one-cycle latency, no read enable.
REQ-015 Read and write SHALL proceed independently in the same cycle (dual-port: one read port, one write port).
REQ-016 Collision (any byte read in the same cycle it is written), without REQ-021 enabled: Dataout SHALL return the pre-write (old) byte values.
REQ-017 Write data SHALL be visible to a read issued in the cycle after the write.

Reset
REQ-018 While nrst=0, Dataout SHALL be 0 immediately (asynchronous), and writes SHALL be blocked.
REQ-019 Memory contents SHALL NOT be cleared by reset; contents are undefined after power-up until written.
REQ-020 On nrst release, the first rising Clk SHALL perform a normal read, and a normal write if Wr=1.

Configuration
REQ-021 Macro MEMORIA_64_BYPASS_EN: when defined, on a collision per REQ-016 each affected byte of Dataout SHALL take the new Datain byte (write-first); when undefined, behaviour is read-first per REQ-016.

Structure
REQ-022 Package memoria_64_pkg SHALL hold DATA_W=64, ADDR_W=64, BYTES_PER_WORD=8, the byte typedef (8-bit logic) and the 64-bit doubleword typedef.
REQ-023 One sub-module memoria_64_bank (byte-wide dual-port array holding the storage, with RAM_SIZE as a parameter) SHALL be used; memoria_64 SHALL contain the address wrap, byte-lane mapping, bypass and output register.

Verification
REQ-024 Reset, Wr=1 for 8 cycles writing waddress=8,16,...,64 with Datain equal to its address, then read raddress=8..64 -> Dataout equals each address, one cycle after each read address is presented.
REQ-025 Write 0x0807060504030201 at address 0; read address 0 -> Dataout=0x0807060504030201; read address 1 -> low byte 0x02, byte 6 = 0x08, byte 7 = old content of byte 8.
REQ-026 Write 0x1122334455667788 at address RAM_SIZE-4 -> bytes wrap to 0..3; read address RAM_SIZE-4 returns the same value; read address 0 -> low 32 bits 0x11223344.
REQ-027 Same-cycle write 0xAAAA... and read at address 16, with old value 0x5555... -> Dataout=0x5555... without the macro, 0xAAAA... with MEMORIA_64_BYPASS_EN.
REQ-028 Assert nrst mid-operation with Wr=1 -> Dataout=0 immediately; the target word keeps its old value; after release, prior contents read back unchanged.
REQ-029 Address 0x0000_0000_0000_1008 with RAM_SIZE=4096 -> behaves identically to address 8.

Source files
------------

// File: rtl/memoria_64_pkg.sv
// Shared widths, byte/doubleword types and sizing helpers for the memoria_64 RAM.
package memoria_64_pkg;
    localparam int DATA_W         = 64;
    localparam int ADDR_W         = 64;
    localparam int BYTES_PER_WORD = 8;
    localparam int OFF_W          = 3;

    typedef logic [7:0]        byte_t;
    typedef logic [DATA_W-1:0] dword_t;
    typedef byte_t [BYTES_PER_WORD-1:0] lanes_t;

    // Row-address width of one byte lane; a single-row lane still gets one bit.
    function automatic int row_bits(input int ram_size);
        int rows;
        rows = ram_size / BYTES_PER_WORD;
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Lane holding byte k of an access starting at byte offset off.
    function automatic logic [OFF_W-1:0] lane_of(input logic [OFF_W-1:0] off,
                                                 input logic [OFF_W-1:0] k);
        return off + k;
    endfunction
endpackage

// File: rtl/memoria_64_bank.sv
// Byte storage split into eight interleaved lanes (lane = byte address mod 8),
// each with its own row address so an unaligned doubleword hits every lane once.
module memoria_64_bank
    import memoria_64_pkg::*;
#(
    parameter  int RAM_SIZE = 4096,
    localparam int ROWS     = RAM_SIZE / BYTES_PER_WORD,
    localparam int ROW_W    = row_bits(RAM_SIZE)
) (
    input  logic                                  clk,
    input  logic                                  we,
    input  logic [BYTES_PER_WORD-1:0][ROW_W-1:0]  wrow,
    input  lanes_t                                wdata,
    input  logic [BYTES_PER_WORD-1:0][ROW_W-1:0]  rrow,
    output lanes_t                                rdata
);
    for (genvar l = 0; l < BYTES_PER_WORD; l++) begin : g_lane
        byte_t mem_q [ROWS];

        always_ff @(posedge clk) begin
            if (we) mem_q[wrow[l]] <= wdata[l];
        end

        // Asynchronous read: the output register in the top samples the pre-write value.
        assign rdata[l] = mem_q[rrow[l]];
    end
endmodule

// File: rtl/memoria_64.sv
// Byte-addressed dual-port RAM with unaligned, wrapping 64-bit accesses.
// Define MEMORIA_64_BYPASS_EN for write-first collisions (default read-first).
module memoria_64
    import memoria_64_pkg::*;
#(
    parameter  int RAM_SIZE = 4096,
    localparam int ROWS     = RAM_SIZE / BYTES_PER_WORD,
    localparam int ROW_W    = row_bits(RAM_SIZE)
) (
    input  logic              Clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] raddress,
    input  logic [ADDR_W-1:0] waddress,
    input  logic [DATA_W-1:0] Datain,
    input  logic              Wr,
    output logic [DATA_W-1:0] Dataout
);
    localparam logic [ROW_W-1:0] ROW_MASK = ROW_W'(ROWS - 1);

    logic [BYTES_PER_WORD-1:0][ROW_W-1:0] wrow, rrow;
    logic [ROW_W-1:0] wbase, rbase;
    logic [OFF_W-1:0] woff, roff;
    lanes_t           din_b, wlane, rlane, rsel, dout_b;
    logic             we;
    dword_t           dout_d, dout_q;
    logic             unused_addr;

    assign unused_addr = ^{raddress[ADDR_W-1:OFF_W+ROW_W], waddress[ADDR_W-1:OFF_W+ROW_W]};
    assign we          = Wr & nrst;

    always_comb begin
        woff   = waddress[OFF_W-1:0];
        roff   = raddress[OFF_W-1:0];
        wbase  = waddress[OFF_W +: ROW_W];
        rbase  = raddress[OFF_W +: ROW_W];
        din_b  = lanes_t'(Datain);
        wrow   = '0;
        rrow   = '0;
        wlane  = '0;
        rsel   = '0;
        dout_b = '0;
        for (int l = 0; l < BYTES_PER_WORD; l++) begin
            // Lanes below the start offset belong to the next row (wraps at top).
            wrow[l]  = (wbase + ROW_W'(OFF_W'(l) < woff)) & ROW_MASK;
            rrow[l]  = (rbase + ROW_W'(OFF_W'(l) < roff)) & ROW_MASK;
            wlane[l] = din_b[OFF_W'(l) - woff];
`ifdef MEMORIA_64_BYPASS_EN
            rsel[l]  = (we && wrow[l] == rrow[l]) ? wlane[l] : rlane[l];
`else
            rsel[l]  = rlane[l];
`endif
        end
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            dout_b[k] = rsel[lane_of(roff, OFF_W'(k))];
        end
        dout_d = dword_t'(dout_b);
    end

    memoria_64_bank #(.RAM_SIZE(RAM_SIZE)) u_bank (
        .clk   (Clk),
        .we    (we),
        .wrow  (wrow),
        .wdata (wlane),
        .rrow  (rrow),
        .rdata (rlane)
    );

    always_ff @(posedge Clk or negedge nrst) begin
        if (!nrst) dout_q <= '0;
        else       dout_q <= dout_d;
    end

    assign Dataout = dout_q;
endmodule

// File: tb/tb_memoria_64.sv
// Directed plus randomized checks of memoria_64 against a flat byte-array model.
module tb_memoria_64;
    localparam int RAM = 4096;

    logic        Clk = 1'b0;
    logic        nrst;
    logic [63:0] raddress, waddress, Datain;
    logic        Wr;
    logic [63:0] Dataout;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mem_m   [RAM];
    bit         valid_m [RAM];

    memoria_64 #(.RAM_SIZE(RAM)) dut (
        .Clk      (Clk),
        .nrst     (nrst),
        .raddress (raddress),
        .waddress (waddress),
        .Datain   (Datain),
        .Wr       (Wr),
        .Dataout  (Dataout)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp,
                         input logic [63:0] mask);
        if (mask == 64'd0) return;   // nothing defined to compare
        vectors++;
        assert ((obs & mask) === (exp & mask)) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h (mask %h)", tag, obs, exp, mask);
        end
    endtask

    // One clock: drive at negedge, update model at posedge, check Dataout after the edge.
    task automatic step(input string tag, input bit wr, input logic [63:0] wa,
                        input logic [63:0] din, input logic [63:0] ra, input bit chk);
        logic [63:0] exp, mask;
        int unsigned idx, widx;
        @(negedge Clk);
        Wr = wr; waddress = wa; Datain = din; raddress = ra;
        exp = '0; mask = '0;
        for (int k = 0; k < 8; k++) begin
            idx = int'((ra + 64'(k)) % 64'(RAM));
            exp[8*k +: 8]  = mem_m[idx];
            mask[8*k +: 8] = valid_m[idx] ? 8'hFF : 8'h00;
`ifdef MEMORIA_64_BYPASS_EN
            if (wr) begin
                for (int j = 0; j < 8; j++) begin
                    if (int'((wa + 64'(j)) % 64'(RAM)) == idx) begin
                        exp[8*k +: 8]  = din[8*j +: 8];
                        mask[8*k +: 8] = 8'hFF;
                    end
                end
            end
`endif
        end
        @(posedge Clk);
        if (wr && nrst) begin
            for (int j = 0; j < 8; j++) begin
                widx = int'((wa + 64'(j)) % 64'(RAM));
                mem_m[widx]   = din[8*j +: 8];
                valid_m[widx] = 1'b1;
            end
        end
        #1;
        if (chk) check(tag, Dataout, exp, mask);
    endtask

    initial begin
        logic [63:0] wa, ra, d;
        for (int i = 0; i < RAM; i++) begin mem_m[i] = 8'h00; valid_m[i] = 1'b0; end
        nrst = 1'b0; Wr = 1'b0; waddress = '0; raddress = '0; Datain = '0;
        #12;
        check("reset_dout", Dataout, 64'd0, '1);
        @(negedge Clk); nrst = 1'b1;

        // Eight aligned writes, then read each back.
        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 64'(8*i), 64'(8*i), 64'd0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step("seq_read", 1'b0, 64'd0, 64'd0, 64'(8*i), 1'b1);
            check("seq_read_const", Dataout, 64'(8*i), '1);
        end

        // Little-endian and unaligned read.
        step("le_wr", 1'b1, 64'd0, 64'h0807060504030201, 64'd8, 1'b1);
        step("le_rd0", 1'b0, 64'd0, 64'd0, 64'd0, 1'b1);
        check("le_rd0_const", Dataout, 64'h0807060504030201, '1);
        step("le_rd1", 1'b0, 64'd0, 64'd0, 64'd1, 1'b1);
        check("le_rd1_const", Dataout, 64'h0808070605040302, '1);

        // Wrap at top of memory.
        step("wrap_wr", 1'b1, 64'(RAM-4), 64'h1122334455667788, 64'd0, 1'b0);
        step("wrap_rd", 1'b0, 64'd0, 64'd0, 64'(RAM-4), 1'b1);
        check("wrap_rd_const", Dataout, 64'h1122334455667788, '1);
        step("wrap_rd0", 1'b0, 64'd0, 64'd0, 64'd0, 1'b1);
        check("wrap_rd0_lo", Dataout & 64'hFFFF_FFFF, 64'h1122_3344, '1);

        // Same-cycle collision.
        step("coll_old", 1'b1, 64'd16, {8{8'h55}}, 64'd0, 1'b0);
        step("coll", 1'b1, 64'd16, {8{8'hAA}}, 64'd16, 1'b1);
`ifdef MEMORIA_64_BYPASS_EN
        check("coll_const", Dataout, {8{8'hAA}}, '1);
`else
        check("coll_const", Dataout, {8{8'h55}}, '1);
`endif

        // Upper address bits ignored.
        step("alias_wr", 1'b1, 64'h1008, 64'hCAFE_F00D_1234_5678, 64'd0, 1'b0);
        step("alias_rd8", 1'b0, 64'd0, 64'd0, 64'd8, 1'b1);
        check("alias_rd8_const", Dataout, 64'hCAFE_F00D_1234_5678, '1);
        step("alias_rdhi", 1'b0, 64'd0, 64'd0, 64'hFFFF_0000_0000_1008, 1'b1);

        // Reset mid-operation with Wr held high.
        step("pre_rst", 1'b0, 64'd0, 64'd0, 64'd24, 1'b1);
        @(negedge Clk);
        Wr = 1'b1; waddress = 64'd24; Datain = 64'hDEAD_BEEF_DEAD_BEEF; raddress = 64'd24;
        nrst = 1'b0;
        #1 check("rst_async", Dataout, 64'd0, '1);
        @(posedge Clk); @(posedge Clk);
        #1 check("rst_hold", Dataout, 64'd0, '1);
        @(negedge Clk); nrst = 1'b1; Wr = 1'b0;
        step("post_rst_rd", 1'b1, 64'd32, 64'h0123_4567_89AB_CDEF, 64'd24, 1'b1);
        check("post_rst_const", Dataout, 64'd24, '1);
        step("post_rst_wr", 1'b0, 64'd0, 64'd0, 64'd32, 1'b1);

        // Randomized traffic, concentrated on a small region and the top edge.
        for (int n = 0; n < 600; n++) begin
            wa = {$urandom, $urandom};
            wa[11:0] = ($urandom_range(0, 3) == 0) ? 12'(RAM - $urandom_range(1, 8))
                                                   : 12'($urandom_range(0, 127));
            if ($urandom_range(0, 2) == 0) ra = wa + 64'($urandom_range(0, 15)) - 64'd8;
            else begin
                ra = {$urandom, $urandom};
                ra[11:0] = ($urandom_range(0, 3) == 0) ? 12'(RAM - $urandom_range(1, 8))
                                                       : 12'($urandom_range(0, 127));
            end
            d = {$urandom, $urandom};
            step("rand", 1'($urandom_range(0, 1)), wa, d, ra, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
